// File: rtl/uart_imem_loader_pkg.sv
// uart_imem_loader_pkg: loader FSM states and byte width,
// shared by uart_imem_loader and uart_word_assembler.
package uart_imem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs UART bytes into a word (endian aware)
// and drops a partial word after TIMEOUT_CYCLES idle cycles.
// Ports: clk, resetn, i_en (accept bytes), i_clr (drop partial),
//   i_valid/i_data (byte in), o_word_valid/o_word (word complete,
//   combinational, includes current byte), o_timeout (expiry pulse).
module uart_word_assembler
  import uart_imem_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int BIG_ENDIAN     = 0,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int DATA_W = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_word_valid,
  output logic [DATA_W-1:0] o_word,
  output logic              o_timeout
);

  localparam int IW =
    (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TLAST);

  logic [IW-1:0]     r_idx;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_word;

  logic              w_take;
  logic              w_last;
  logic              w_expire;
  logic [DATA_W-1:0] w_word;
  int                w_slot;

  assign w_take = i_en && i_valid;
  assign w_last = (r_idx == IDX_LAST);

  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_expire = (TIMEOUT_CYCLES > 0) && i_en && !i_valid &&
                    (r_idx != '0) && (r_timer == T_LAST);

  always_comb begin
    w_slot = (BIG_ENDIAN != 0) ?
             (BYTES_PER_WORD - 1 - int'(r_idx)) : int'(r_idx);
    w_word = r_word;
    w_word[w_slot*BYTE_W +: BYTE_W] = i_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx   <= '0;
      r_timer <= '0;
      r_word  <= '0;
    end else if (i_clr) begin
      r_idx   <= '0;
      r_timer <= '0;
    end else if (w_take) begin
      r_word  <= w_word;
      r_timer <= '0;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end else if (w_expire) begin
      r_idx   <= '0;
      r_timer <= '0;
    end else if (i_en && (r_idx != '0)) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  assign o_word_valid = w_take && w_last && !i_clr;
  assign o_word       = w_word;
  assign o_timeout    = w_expire && !i_clr;

endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: UART byte stream -> instruction memory writes,
// end-marker detect, timeout/overflow errors, break restart.
// Ports: clk, resetn, load_en, rx_valid, rx_data, rx_break in;
//   imem_we/addr/wdata, write_done, core_resetn, word_count,
//   timeout_err, overflow_err out. With UART_IMEM_LOADER_CHECKSUM_EN:
//   expected_sum in, checksum out; DONE requires a matching sum.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 10,
  parameter int DEPTH          = 1024,
  parameter int BIG_ENDIAN     = 0,
  parameter int END_MARK_COUNT = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int DATA_W = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              write_done,
  output logic              core_resetn,
  output logic [ADDR_W:0]   word_count,
  output logic              timeout_err,
  output logic              overflow_err
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  ,
  input  logic [DATA_W-1:0] expected_sum,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int MW = $clog2(END_MARK_COUNT + 1);
  localparam logic [MW-1:0]   MARK_END = MW'(END_MARK_COUNT);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  state_e            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_done;
  logic [ADDR_W:0]   r_count;
  logic [MW-1:0]     r_mark;
  logic              r_terr;
  logic              r_oerr;

  logic              w_asm_en;
  logic              w_asm_clr;
  logic              w_word_valid;
  logic [DATA_W-1:0] w_word;
  logic              w_timeout;
  logic [MW-1:0]     w_mark_nxt;
  logic              w_sum_ok;

  // Bytes are still taken during WRITE; they start the next word.
  assign w_asm_en  = ((r_state == COLLECT) && load_en) ||
                     (r_state == WRITE);
  assign w_asm_clr = rx_break ||
                     ((r_state == COLLECT) && !load_en);

  uart_word_assembler #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BIG_ENDIAN     (BIG_ENDIAN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk          (clk),
    .resetn       (resetn),
    .i_en         (w_asm_en),
    .i_clr        (w_asm_clr),
    .i_valid      (rx_valid),
    .i_data       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word),
    .o_timeout    (w_timeout)
  );

  assign w_mark_nxt = r_mark + 1'b1;

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + r_wdata;
  assign w_sum_ok  = (w_sum_nxt == expected_sum);
  assign checksum  = r_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sum <= '0;
    end else if (rx_break) begin
      r_sum <= '0;
    end else if (r_we) begin
      r_sum <= w_sum_nxt;
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_mark  <= '0;
      r_terr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else if (rx_break) begin
      r_state <= load_en ? COLLECT : IDLE;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_mark  <= '0;
      r_terr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_timeout) r_terr <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (load_en) r_state <= COLLECT;
        end
        COLLECT: begin
          if (!load_en) begin
            r_state <= IDLE;
          end else if (w_word_valid) begin
            // A full memory suppresses the strobe; WRITE then errors.
            r_state <= WRITE;
            r_we    <= (r_count != CNT_FULL);
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_word;
          end
        end
        WRITE: begin
          if (!r_we) begin
            r_oerr  <= 1'b1;
            r_state <= ERROR;
          end else begin
            r_count <= r_count + 1'b1;
            if (&r_wdata) begin
              r_mark <= w_mark_nxt;
              if (w_mark_nxt == MARK_END) begin
                r_done  <= w_sum_ok;
                r_state <= w_sum_ok ? DONE : ERROR;
              end else begin
                r_state <= COLLECT;
              end
            end else begin
              r_mark  <= '0;
              r_state <= COLLECT;
            end
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign write_done   = r_done;
  assign core_resetn  = r_done;
  assign word_count   = r_count;
  assign timeout_err  = r_terr;
  assign overflow_err = r_oerr;

endmodule
